// File: rtl/keccak_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : keccak_arbiter
//  Purpose  : Round-robin sharing of one Keccak permutation core between
//             N_REQ requesters. A grant is held across a sequence of
//             permutations until the requester flags its final start.
//  Revision : 1.0  initial release
// ============================================================================
module keccak_arbiter #(
  parameter int N_REQ   = 3,
  parameter int STATE_W = 1600
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [N_REQ-1:0]                req_i,
  input  logic [N_REQ-1:0]                start_i,
  input  logic [N_REQ-1:0]                last_i,
  input  logic [N_REQ-1:0][STATE_W-1:0]   state_i,
  output logic [N_REQ-1:0]                gnt_o,
  output logic [N_REQ-1:0]                done_o,
  output logic [STATE_W-1:0]              state_o,
  output logic                            busy_o,
  output logic                            core_start_o,
  output logic [STATE_W-1:0]              core_state_o,
  input  logic                            core_ready_i,
  input  logic [STATE_W-1:0]              core_state_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic                 last_q, last_d;
  logic                 ready_prev_q, ready_prev_d;
  logic [N_REQ-1:0]     done_q, done_d;
  logic                 core_start_q, core_start_d;
  logic [STATE_W-1:0]   core_state_q, core_state_d;

  logic                 w_any_req;
  logic [IDX_W-1:0]     w_sel_idx;
  logic [IDX_W-1:0]     w_cand;
  logic                 w_ready_rise;
  logic [IDX_W-1:0]     w_rel_ptr;

  // Round-robin pick: first requester at or after ptr, wrapping around.
  // Scanning from the far end lets the closest candidate win last.
  always_comb begin
    w_any_req = 1'b0;
    w_sel_idx = '0;
    w_cand    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_cand = IDX_W'((int'(ptr_q) + i) % N_REQ);
      if (req_i[w_cand]) begin
        w_any_req = 1'b1;
        w_sel_idx = w_cand;
      end
    end
  end

  // Completion is the rising edge of Ready; ready_prev resets high so a core
  // that wakes up with Ready asserted is not mistaken for a finished run.
  assign w_ready_rise = core_ready_i & ~ready_prev_q;
  assign w_rel_ptr    = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

  // Next-state and output logic for the grant / launch / completion FSM.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    gnt_d        = gnt_q;
    last_d       = last_q;
    done_d       = '0;
    core_start_d = 1'b0;
    core_state_d = core_state_q;
    ready_prev_d = core_ready_i;
    case (state_q)
      ST_IDLE: begin
        if (w_any_req) begin
          idx_d            = w_sel_idx;
          gnt_d            = '0;
          gnt_d[w_sel_idx] = 1'b1;
          state_d          = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A start wins over a simultaneous request drop.
        if (start_i[idx_q]) begin
          last_d       = last_i[idx_q];
          core_state_d = state_i[idx_q];
          core_start_d = 1'b1;
          state_d      = ST_BUSY;
        end else if (!req_i[idx_q]) begin
          gnt_d   = '0;
          ptr_d   = w_rel_ptr;
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Request drops are honoured only once the permutation finishes.
        if (w_ready_rise) begin
          done_d = gnt_q;
          if (last_q || !req_i[idx_q]) begin
            gnt_d   = '0;
            ptr_d   = w_rel_ptr;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GRANT;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with asynchronous clear of every output and pointer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      idx_q        <= '0;
      gnt_q        <= '0;
      last_q       <= 1'b0;
      ready_prev_q <= 1'b1;
      done_q       <= '0;
      core_start_q <= 1'b0;
      core_state_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      gnt_q        <= gnt_d;
      last_q       <= last_d;
      ready_prev_q <= ready_prev_d;
      done_q       <= done_d;
      core_start_q <= core_start_d;
      core_state_q <= core_state_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign done_o       = done_q;
  assign busy_o       = (state_q == ST_BUSY);
  assign core_start_o = core_start_q;
  assign core_state_o = core_state_q;
  assign state_o      = core_state_i;

endmodule
`default_nettype wire

// File: tb/tb_keccak_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_keccak_arbiter
//  Purpose  : Scoreboard bench for keccak_arbiter with a behavioural core.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keccak_arbiter;

  localparam int N   = 3;
  localparam int SW  = 1600;
  localparam int LAT = 4;

  typedef struct packed {
    logic [N-1:0]  g;
    logic [SW-1:0] d;
  } done_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N-1:0]           req, start, last;
  logic [N-1:0][SW-1:0]   st_in;
  logic                   ready;
  logic [SW-1:0]          core_out;
  logic [N-1:0]           gnt, done;
  logic [SW-1:0]          st_out, cstate;
  logic                   busy, cstart;

  logic [SW-1:0]          exp_start_q[$];
  done_t                  exp_done_q[$];
  logic [N-1:0]           exp_gnt_q[$];

  int vec_cnt = 0;
  int err_cnt = 0;

  keccak_arbiter #(.N_REQ(N), .STATE_W(SW)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_i        (req),
    .start_i      (start),
    .last_i       (last),
    .state_i      (st_in),
    .gnt_o        (gnt),
    .done_o       (done),
    .state_o      (st_out),
    .busy_o       (busy),
    .core_start_o (cstart),
    .core_state_o (cstate),
    .core_ready_i (ready),
    .core_state_i (core_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] fold(input logic [SW-1:0] v);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < SW / 64; i++) r = {r[62:0], r[63]} ^ v[i*64 +: 64];
    return r;
  endfunction

  function automatic logic [SW-1:0] perm(input logic [SW-1:0] v);
    logic [SW-1:0] k;
    k = {(SW/64){64'h0123_4567_89ab_cdef}};
    return {v[0], v[SW-1:1]} ^ k;
  endfunction

  function automatic logic [SW-1:0] mk_state(input int id, input int seq);
    logic [31:0] w;
    w = 32'h1357_9bdf ^ (32'(id) << 24) ^ (32'(seq) << 4);
    return {(SW/32){w}} ^ (SW'(id + 1) << (seq * 7 + id * 300));
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_states(input int seq);
    for (int i = 0; i < N; i++) st_in[i] = mk_state(i, seq);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_gnt"},    64'(gnt),    64'd0);
    chk({tag, "_done"},   64'(done),   64'd0);
    chk({tag, "_busy"},   64'(busy),   64'd0);
    chk({tag, "_cstart"}, 64'(cstart), 64'd0);
    chk({tag, "_cstate"}, fold(cstate), 64'd0);
  endtask

  task automatic apply_reset();
    req   = '0;
    start = '0;
    last  = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk_outputs_zero("rst");
    rst_n = 1'b1;
    tick();
  endtask

  // Issue a start for requester idx and book the resulting launch and done.
  task automatic do_start(input int idx, input logic l, input int seq);
    done_t e;
    set_states(seq);
    e.g = oh(idx);
    e.d = perm(st_in[idx]);
    exp_start_q.push_back(st_in[idx]);
    exp_done_q.push_back(e);
    start[idx] = 1'b1;
    last[idx]  = l;
    tick();
    start = '0;
    last  = '0;
    chk("start_latency", 64'(cstart), 64'd1);
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input int idx);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done[idx] && n < 40);
    chk("done_wait", 64'(done[idx]), 64'd1);
  endtask

  // Behavioural core: Ready drops after a launch and rises LAT cycles later.
  initial begin
    logic          cs;
    logic [SW-1:0] cd, held;
    int            cnt;
    ready    = 1'b1;
    core_out = '0;
    held     = '0;
    cnt      = 0;
    forever begin
      @(posedge clk);
      cs = cstart;
      cd = cstate;
      #1;
      if (cs) begin
        ready = 1'b0;
        cnt   = LAT;
        held  = cd;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          ready    = 1'b1;
          core_out = perm(held);
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a launch, a done
  // or a new grant.
  logic         prev_ready = 1'b1;
  logic         rise_pend  = 1'b0;
  logic [N-1:0] prev_gnt   = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cstart) begin
        if (exp_start_q.size() == 0) chk("unexpected_core_start", 64'd1, 64'd0);
        else chk("core_state", fold(cstate), fold(exp_start_q.pop_front()));
      end
      if (done != '0) begin
        if (exp_done_q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          done_t e;
          e = exp_done_q.pop_front();
          chk("done_o", 64'(done), 64'(e.g));
          chk("state_o", fold(st_out), fold(e.d));
        end
        chk("busy_at_done", 64'(busy), 64'd0);
      end
      if (rise_pend || done != '0)
        chk("done_timing", 64'(done != '0), 64'(rise_pend));
      if (gnt != '0 && gnt != prev_gnt) begin
        if (exp_gnt_q.size() == 0) chk("unexpected_gnt", 64'(gnt), 64'd0);
        else chk("gnt_order", 64'(gnt), 64'(exp_gnt_q.pop_front()));
        chk("gnt_gap", 64'(prev_gnt), 64'd0);
      end
      rise_pend <= busy && ready && !prev_ready;
    end else begin
      rise_pend <= 1'b0;
    end
    prev_ready <= ready;
    prev_gnt   <= gnt;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    start = '0;
    last  = '0;
    set_states(0);
    apply_reset();
    repeat (5) tick();

    // Single requester, single last permutation.
    exp_gnt_q.push_back(3'b001);
    req = 3'b001;
    tick();
    chk("t1_gnt", 64'(gnt), 64'(3'b001));
    do_start(0, 1'b1, 1);
    wait_done(0);
    chk("t1_gnt_release", 64'(gnt), 64'd0);
    req = '0;
    repeat (3) tick();

    // All three requesting: round-robin 0,1,2,0 with one idle cycle between.
    apply_reset();
    for (int k = 0; k < 4; k++) exp_gnt_q.push_back(oh(k % 3));
    req = 3'b111;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t2_gnt", 64'(gnt), 64'(oh(k % 3)));
      do_start(k % 3, 1'b1, 10 + k);
      wait_done(k % 3);
      chk("t2_gnt_release", 64'(gnt), 64'd0);
      if (k == 3) req = '0;
      tick();
    end
    repeat (3) tick();

    // Requester 1 runs five permutations; requester 2 waits for the last.
    apply_reset();
    exp_gnt_q.push_back(3'b010);
    exp_gnt_q.push_back(3'b100);
    req = 3'b110;
    tick();
    chk("t3_gnt1", 64'(gnt), 64'(3'b010));
    for (int s = 0; s < 5; s++) begin
      do_start(1, s == 4, 20 + s);
      wait_done(1);
      if (s < 4) begin
        chk("t3_gnt_held", 64'(gnt), 64'(3'b010));
      end else begin
        chk("t3_gnt_release", 64'(gnt), 64'd0);
        req[1] = 1'b0;
      end
    end
    tick();
    chk("t3_gnt2", 64'(gnt), 64'(3'b100));
    do_start(2, 1'b1, 30);
    wait_done(2);
    req = '0;
    repeat (3) tick();

    // Stray starts in IDLE, from a non-granted requester, and during BUSY;
    // request dropped mid-permutation releases only at completion.
    apply_reset();
    start[1] = 1'b1;
    tick();
    start = '0;
    chk("t4_idle_start", 64'(cstart), 64'd0);
    exp_gnt_q.push_back(3'b001);
    req = 3'b001;
    tick();
    chk("t4_gnt", 64'(gnt), 64'(3'b001));
    start[2] = 1'b1;
    last[2]  = 1'b1;
    tick();
    start = '0;
    last  = '0;
    chk("t4_foreign_start", 64'(cstart), 64'd0);
    chk("t4_gnt_kept", 64'(gnt), 64'(3'b001));
    do_start(0, 1'b0, 40);
    start[0] = 1'b1;
    req      = '0;
    tick();
    start = '0;
    chk("t4_gnt_in_busy", 64'(gnt), 64'(3'b001));
    wait_done(0);
    chk("t4_release_on_drop", 64'(gnt), 64'd0);
    repeat (4) tick();

    // Asynchronous reset in the middle of a permutation.
    apply_reset();
    exp_gnt_q.push_back(3'b001);
    req = 3'b001;
    tick();
    do_start(0, 1'b1, 50);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("t5_async");
    exp_done_q.delete();
    req = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();

    // Ready high straight out of reset while granted: no completion.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    exp_gnt_q.push_back(3'b001);
    req = 3'b001;
    repeat (6) tick();
    chk("t6_gnt", 64'(gnt), 64'(3'b001));
    chk("t6_no_done", 64'(done), 64'd0);
    do_start(0, 1'b1, 60);
    wait_done(0);
    req = '0;
    repeat (5) tick();

    chk("left_start", 64'(exp_start_q.size()), 64'd0);
    chk("left_done",  64'(exp_done_q.size()),  64'd0);
    chk("left_gnt",   64'(exp_gnt_q.size()),   64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keccak_arbiter.md
# keccak_arbiter

Shares one `keccak_top` permutation core between up to `N_REQ` requesters: the matrix sampler XOF, the CBD PRF and the G/H hashes. Each requester holds a grant for a sequence of one or more permutations. It ends the sequence by flagging its final start with `last_i`. The block applies round-robin priority, muxes the 1600-bit input state, launches the core, detects completion and returns a per-requester done pulse.

## Interface
Parameters:
- `N_REQ`, 3: number of requesters (2..8).
- `STATE_W`, 1600: Keccak state width.

Ports:
- `clk_i`  in  1: single clock.
- `rst_n_i`  in  1: asynchronous active-low reset; clears all state.
- `req_i`  in  N_REQ: request lines, level; a requester holds its line high for the whole sequence.
- `start_i`  in  N_REQ: one-cycle pulse; launches a permutation for the granted requester.
- `last_i`  in  N_REQ: sampled with `start_i`; when 1, the grant is released after this permutation.
- `state_i`  in  N_REQ×STATE_W: per-requester input state.
- `gnt_o`  out  N_REQ: one-hot grant, registered.
- `done_o`  out  N_REQ: one-cycle pulse to the granted requester when its permutation completes.
- `state_o`  out  STATE_W: core output, combinational passthrough of `core_state_i` to all requesters.
- `busy_o`  out  1: high while a permutation is in flight.
- `core_start_o`  out  1: drives the core `Reset` input, registered pulse.
- `core_state_o`  out  STATE_W: drives the core `InData`, registered.
- `core_ready_i`  in  1: core `Ready`.
- `core_state_i`  in  STATE_W: core `OutData`.

## Operation
- FSM states:
  - IDLE (reset state).
  - GRANT: a requester owns the core and no permutation is running.
  - BUSY: a permutation is running.
- Round-robin pointer `ptr` (reset 0):
  - In IDLE, grant the first requester with `req_i` high, scanning from `ptr` upward with wrap-around.
  - On release, `ptr` becomes the granted index + 1, wrapping at N_REQ.
- IDLE -> GRANT: any `req_i` high. Set `gnt_o` one-hot to the chosen index `g`.
- In GRANT:
  - `start_i[g]` high -> latch `last_i[g]`, load `core_state_o <= state_i[g]`, pulse `core_start_o`, go to BUSY.
  - `req_i[g]` low with no start -> release; go to IDLE and update `ptr`.
- In BUSY:
  - Wait for a rising edge of `core_ready_i` (`ready_prev` = 0, `core_ready_i` = 1).
  - On that edge, pulse `done_o[g]`.
  - If the latched last flag is 1 or `req_i[g]` is low -> release to IDLE and update `ptr`.
  - Otherwise -> GRANT, and `gnt_o` is held.
- Ignored inputs:
  - `start_i` from a non-granted requester, in any state.
  - Any `start_i` while in BUSY.
  - `start_i` while in IDLE.
- A `req_i[g]` drop during BUSY does not abort the permutation. Release happens at completion.
- `ready_prev` resets to 1, so a core that comes out of reset with Ready high does not produce a false completion.
- `state_o` is valid in the cycle `done_o` pulses and stays valid until the next `core_start_o`.

## Timing
- Reset values: `gnt_o`=0, `done_o`=0, `busy_o`=0, `core_start_o`=0, `core_state_o`=0, `ptr`=0, FSM=IDLE.
- Grant latency: `req_i` high in cycle t while IDLE -> `gnt_o` set at t+1.
- Start latency: `start_i[g]` in cycle t -> `core_start_o` high for exactly one cycle at t+1, with `core_state_o` valid in the same cycle. `busy_o` is high from t+1.
- Completion: `core_ready_i` rises at cycle r -> `done_o[g]` high at r+1 and `busy_o` low at r+1.
- Release at r+1:
  - `gnt_o` clears at r+1.
  - A new grant can appear at r+2 at the earliest, giving one idle cycle between owners.
- Back-to-back in the same grant: the requester may pulse `start_i` in the same cycle it sees `done_o`. That is a legal GRANT-state start, and `core_start_o` follows at r+2.
- Asynchronous reset mid-BUSY: all outputs clear immediately. No `done_o` is issued for the aborted permutation. The core is re-launched only by a new sequence.

## Test plan
- Single requester 0 with `req_i`=001 and `start_i[0]` plus `last_i[0]` at the cycle after the grant:
  - `gnt_o`=001 one cycle after `req_i`.
  - One `core_start_o` pulse, with `core_state_o` equal to `state_i[0]`.
  - `done_o`=001 one cycle after the modeled Ready rises, then `gnt_o`=000.
- All three requests held continuously, each issuing a single last start:
  - Grant order is 0, 1, 2, 0.
  - There is exactly one idle cycle between grants.
- Requester 1 issues 5 starts, with `last_i` only on the 5th:
  - The grant is held through 5 `done_o[1]` pulses.
  - Requester 2, requesting throughout, is granted only after the 5th pulse.
- Stray starts:
  - `start_i[2]` pulsed while requester 0 is granted, and `start_i[0]` pulsed during BUSY -> no extra `core_start_o`, no extra `done_o`.
- Reset cases:
  - `rst_n_i` pulled low during BUSY -> all outputs 0 asynchronously, no `done_o` after reset release.
  - Core Ready held high out of reset -> no spurious `done_o`.
